// File: rtl/dual_slope_pkg.sv
// Shared constants and state encoding for the dual-slope ADC counter and its control machine.
package dual_slope_pkg;

    localparam int DS_COUNT_WIDTH = 12;
    localparam int DS_INT_CYCLES  = 1000;
    localparam int DS_SYNC_STAGES = 2;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN_UP   = 2'd1;
    localparam logic [1:0] ST_RUN_DOWN = 2'd2;
    localparam logic [1:0] ST_HOLD     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        RUN_UP   = ST_RUN_UP,
        RUN_DOWN = ST_RUN_DOWN,
        HOLD     = ST_HOLD
    } ds_state_e;

endpackage

// File: rtl/dual_slope_counter_sync_ff.sv
// STAGES-deep flop synchronizer for a single asynchronous input (e.g. a comparator output).
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage deeper each cycle.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer stage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dual_slope_counter.sv
// Dual-slope ADC counting datapath: fixed run-up window, run-down until discharge, result latch.
// Optional DUAL_SLOPE_PROTOCOL_CHECK_EN adds a sticky protocol_error output.
module dual_slope_counter
    import dual_slope_pkg::*;
#(
    parameter int COUNT_WIDTH = DS_COUNT_WIDTH,
    parameter int INT_CYCLES  = DS_INT_CYCLES,
    parameter int SYNC_STAGES = DS_SYNC_STAGES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear_count,
    input  logic                   enable_counting,
    input  logic                   ch_Vmeasured,
    input  logic                   ch_Vref,
    input  logic                   cap_discharged,
    output logic                   finished_counting,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] result,
    output logic                   result_valid,
    output logic                   overflow
`ifdef DUAL_SLOPE_PROTOCOL_CHECK_EN
    ,
    output logic                   protocol_error
`endif
);

    localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = {COUNT_WIDTH{1'b1}};
    localparam logic [COUNT_WIDTH-1:0] ZERO      = {COUNT_WIDTH{1'b0}};
    localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] UP_LAST   = COUNT_WIDTH'(INT_CYCLES - 1);

    ds_state_e              state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] result_q, result_d;
    logic                   valid_q, valid_d;
    logic                   ovf_q, ovf_d;
    logic                   fin_q, fin_d;
    logic                   cap_sync_s;
    logic                   up_s;
    logic                   dn_s;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_cap_sync (
        .clk (clk),
        .rst (reset),
        .d   (cap_discharged),
        .q   (cap_sync_s)
    );

    // Qualifying cycles; both selects high qualifies neither phase.
    always_comb begin
        up_s = enable_counting & ch_Vmeasured & ~ch_Vref;
        dn_s = enable_counting & ch_Vref & ~ch_Vmeasured;
    end

    // Next-state and datapath update; clear_count overrides all phase logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        fin_d    = 1'b0;
        if (clear_count) begin
            state_d = IDLE;
            count_d = ZERO;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (up_s) begin
                        if (INT_CYCLES == 1) begin
                            count_d = ZERO;
                            fin_d   = 1'b1;
                            state_d = RUN_DOWN;
                        end else begin
                            count_d = ONE;
                            state_d = RUN_UP;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                RUN_UP: begin
                    if (up_s) begin
                        if (count_q == UP_LAST) begin
                            count_d = ZERO;
                            fin_d   = 1'b1;
                            state_d = RUN_DOWN;
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                RUN_DOWN: begin
                    // The latched count deliberately includes the synchronizer delay.
                    if (dn_s) begin
                        if (cap_sync_s) begin
                            result_d = count_q;
                            valid_d  = 1'b1;
                            fin_d    = 1'b1;
                            state_d  = HOLD;
                        end else if (count_q == MAX_COUNT) begin
                            result_d = MAX_COUNT;
                            ovf_d    = 1'b1;
                            valid_d  = 1'b1;
                            fin_d    = 1'b1;
                            state_d  = HOLD;
                        end else begin
                            count_d = count_q + ONE;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    state_d = IDLE;
                    count_d = ZERO;
                end
            endcase
        end
    end

    // Main state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            result_q <= ZERO;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            fin_q    <= fin_d;
        end
    end

    assign finished_counting = fin_q;
    assign count             = count_q;
    assign result            = result_q;
    assign result_valid      = valid_q;
    assign overflow          = ovf_q;

`ifdef DUAL_SLOPE_PROTOCOL_CHECK_EN
    logic perr_q, perr_d;

    // Sticky flag for conflicting selects or a premature run-down request.
    always_comb begin
        perr_d = perr_q;
        if (clear_count) begin
            perr_d = 1'b0;
        end else if ((ch_Vmeasured & ch_Vref) ||
                     (ch_Vref & enable_counting &
                      ((state_q == IDLE) || (state_q == RUN_UP)))) begin
            perr_d = 1'b1;
        end else begin
            perr_d = perr_q;
        end
    end

    // Protocol error register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign protocol_error = perr_q;
`endif

endmodule

// File: tb/tb_dual_slope_counter.sv
// Directed scoreboard bench for dual_slope_counter (COUNT_WIDTH=4, INT_CYCLES=8, SYNC_STAGES=2).
module tb_dual_slope_counter;

    localparam int CW = 4;
    localparam int IC = 8;
    localparam int SS = 2;

    localparam int F_CNT  = 0;
    localparam int F_RES  = 1;
    localparam int F_VAL  = 2;
    localparam int F_FIN  = 3;
    localparam int F_OVF  = 4;
    localparam int F_PERR = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_count;
    logic          enable_counting;
    logic          ch_Vmeasured;
    logic          ch_Vref;
    logic          cap_discharged;
    logic          finished_counting;
    logic [CW-1:0] count;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          overflow;
`ifdef DUAL_SLOPE_PROTOCOL_CHECK_EN
    logic          protocol_error;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        string tag;
        int    fld;
        int    val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    dual_slope_counter #(
        .COUNT_WIDTH (CW),
        .INT_CYCLES  (IC),
        .SYNC_STAGES (SS)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .clear_count       (clear_count),
        .enable_counting   (enable_counting),
        .ch_Vmeasured      (ch_Vmeasured),
        .ch_Vref           (ch_Vref),
        .cap_discharged    (cap_discharged),
        .finished_counting (finished_counting),
        .count             (count),
        .result            (result),
        .result_valid      (result_valid),
        .overflow          (overflow)
`ifdef DUAL_SLOPE_PROTOCOL_CHECK_EN
        ,
        .protocol_error    (protocol_error)
`endif
    );

    function automatic integer obs(int f);
        case (f)
            F_CNT:  return integer'(count);
            F_RES:  return integer'(result);
            F_VAL:  return integer'(result_valid);
            F_FIN:  return integer'(finished_counting);
            F_OVF:  return integer'(overflow);
`ifdef DUAL_SLOPE_PROTOCOL_CHECK_EN
            F_PERR: return integer'(protocol_error);
`endif
            default: return -1;
        endcase
    endfunction

    task automatic push(string tag, int fld, int val);
        exp_t e;
        e.tag = tag;
        e.fld = fld;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic push_all(string tag, int c, int r, int v, int fin, int ovf);
        push({tag, ".count"}, F_CNT, c);
        push({tag, ".result"}, F_RES, r);
        push({tag, ".valid"}, F_VAL, v);
        push({tag, ".fin"}, F_FIN, fin);
        push({tag, ".ovf"}, F_OVF, ovf);
    endtask

    task automatic check_sb();
        exp_t   e;
        integer o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.fld);
            total_cnt++;
            assert (o === e.val) pass_cnt++;
            else $error("FAIL %s: observed %0d expected %0d", e.tag, o, e.val);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_clear();
        clear_count = 1'b1;
        step(1);
        clear_count = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        clear_count     = 1'b0;
        enable_counting = 1'b0;
        ch_Vmeasured    = 1'b0;
        ch_Vref         = 1'b0;
        cap_discharged  = 1'b0;
        step(2);
        push_all("reset", 0, 0, 0, 0, 0);
        check_sb();
        reset = 1'b0;
        step(1);

        // Full conversion: result 7 latched three edges after the cap rise.
        enable_counting = 1'b1;
        ch_Vmeasured    = 1'b1;
        step(7);
        push("conv.up7.count", F_CNT, 7);
        push("conv.up7.fin", F_FIN, 0);
        check_sb();
        step(1);
        push("conv.up8.count", F_CNT, 0);
        push("conv.up8.fin", F_FIN, 1);
        check_sb();
        ch_Vmeasured = 1'b0;
        ch_Vref      = 1'b1;
        step(5);
        push("conv.dn5.count", F_CNT, 5);
        push("conv.dn5.fin", F_FIN, 0);
        check_sb();
        cap_discharged = 1'b1;
        step(2);
        push("conv.sync.count", F_CNT, 7);
        push("conv.sync.valid", F_VAL, 0);
        check_sb();
        step(1);
        push_all("conv.latch", 7, 7, 1, 1, 0);
        check_sb();
        step(2);
        push_all("conv.hold", 7, 7, 1, 0, 0);
        check_sb();
        cap_discharged = 1'b0;
        do_clear();
        push_all("conv.clear", 0, 7, 0, 0, 0);
        check_sb();

        // Overflow: run-down saturates at 15 without discharge.
        ch_Vref      = 1'b0;
        ch_Vmeasured = 1'b1;
        step(8);
        push("ovf.up.fin", F_FIN, 1);
        check_sb();
        ch_Vmeasured = 1'b0;
        ch_Vref      = 1'b1;
        step(15);
        push_all("ovf.dn15", 15, 7, 0, 0, 0);
        check_sb();
        step(1);
        push_all("ovf.sat", 15, 15, 1, 1, 1);
        check_sb();
        step(3);
        push_all("ovf.hold", 15, 15, 1, 0, 1);
        check_sb();
        do_clear();
        push_all("ovf.clear", 0, 15, 0, 0, 0);
        check_sb();

        // Pause: three disabled cycles at count 4 delay the pulse by three.
        ch_Vref      = 1'b0;
        ch_Vmeasured = 1'b1;
        step(4);
        push("pause.count4", F_CNT, 4);
        check_sb();
        enable_counting = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            push("pause.hold.count", F_CNT, 4);
            push("pause.hold.fin", F_FIN, 0);
            check_sb();
        end
        enable_counting = 1'b1;
        step(3);
        push("pause.pre.count", F_CNT, 7);
        push("pause.pre.fin", F_FIN, 0);
        check_sb();
        step(1);
        push("pause.end.count", F_CNT, 0);
        push("pause.end.fin", F_FIN, 1);
        check_sb();
        ch_Vmeasured = 1'b0;
        ch_Vref      = 1'b1;
        step(7);
        cap_discharged = 1'b1;
        step(2);
        push("res9.sync.count", F_CNT, 9);
        push("res9.sync.valid", F_VAL, 0);
        check_sb();
        step(1);
        push_all("res9.latch", 9, 9, 1, 1, 0);
        check_sb();
        cap_discharged = 1'b0;
        do_clear();

        // clear_count mid run-down keeps the prior result and gives no pulse.
        ch_Vref      = 1'b0;
        ch_Vmeasured = 1'b1;
        step(8);
        ch_Vmeasured = 1'b0;
        ch_Vref      = 1'b1;
        step(6);
        push_all("midclr.dn6", 6, 9, 0, 0, 0);
        check_sb();
        do_clear();
        push_all("midclr.clear", 0, 9, 0, 0, 0);
        check_sb();
        step(1);
        push_all("midclr.idle", 0, 9, 0, 0, 0);
        check_sb();

        // Both selects high in run-up: no qualifying cycles.
        ch_Vref      = 1'b0;
        ch_Vmeasured = 1'b0;
        do_clear();
        ch_Vmeasured = 1'b1;
        step(3);
        push("both.pre.count", F_CNT, 3);
`ifdef DUAL_SLOPE_PROTOCOL_CHECK_EN
        push("both.pre.perr", F_PERR, 0);
`endif
        check_sb();
        ch_Vref = 1'b1;
        step(2);
        push("both.hold.count", F_CNT, 3);
`ifdef DUAL_SLOPE_PROTOCOL_CHECK_EN
        push("both.hold.perr", F_PERR, 1);
`endif
        check_sb();
        ch_Vref = 1'b0;
        step(1);
        push("both.resume.count", F_CNT, 4);
`ifdef DUAL_SLOPE_PROTOCOL_CHECK_EN
        push("both.resume.perr", F_PERR, 1);
`endif
        check_sb();
        do_clear();
        push("both.clear.count", F_CNT, 0);
`ifdef DUAL_SLOPE_PROTOCOL_CHECK_EN
        push("both.clear.perr", F_PERR, 0);
`endif
        check_sb();

        // Asynchronous reset mid run-up at count 5.
        step(5);
        push_all("arst.pre", 5, 9, 0, 0, 0);
        check_sb();
        #2;
        reset = 1'b1;
        #1;
        push_all("arst.async", 0, 0, 0, 0, 0);
        check_sb();
        step(1);
        reset           = 1'b0;
        enable_counting = 1'b0;
        step(1);
        push_all("arst.idle", 0, 0, 0, 0, 0);
        check_sb();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dual_slope_counter.md
Name: dual_slope_counter

Overview:
- Counting datapath for the dual-slope ADC, driven by the control machine.
- Consumes the control machine's phase selects, counter clear and enable.
- Produces finished_counting back to the control machine and the final conversion code.
- Run-up phase counts a fixed INT_CYCLES window. Run-down phase counts until the comparator reports capacitor discharge, then latches the count as the result.

Parameters:
- COUNT_WIDTH, 12: width of count and result; MAX = 2^COUNT_WIDTH-1.
- INT_CYCLES, 1000: run-up length in qualifying cycles; must satisfy 1 <= INT_CYCLES <= MAX.
- SYNC_STAGES, 2: flop stages on the asynchronous cap_discharged input; minimum 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear_count  in  1  synchronous clear from the control machine's reset output.
- enable_counting  in  1  count enable from the control machine.
- ch_Vmeasured  in  1  run-up phase select.
- ch_Vref  in  1  run-down phase select.
- cap_discharged  in  1  comparator output; asynchronous to clk.
- finished_counting  out  1  registered one-cycle pulse at the end of each phase.
- count  out  COUNT_WIDTH  live counter value.
- result  out  COUNT_WIDTH  latched conversion code.
- result_valid  out  1  level; high from result latch until clear_count or reset.
- overflow  out  1  level; run-down saturated without discharge.

Behaviour:
- Reset values: state=IDLE, count=0, result=0, finished_counting=0, result_valid=0, overflow=0, synchronizer flops=0.
- cap_sync is cap_discharged after SYNC_STAGES flops.
- up_q = enable_counting & ch_Vmeasured & ~ch_Vref.
- dn_q = enable_counting & ch_Vref & ~ch_Vmeasured.
- finished_counting defaults to 0 every cycle; it is a pulse only.
- Priority per edge: reset > clear_count > state logic.
- clear_count:
  - Sets state=IDLE, count=0, result_valid=0, overflow=0.
  - result is retained.
  - Allowed in any state, including mid-phase; it aborts the conversion with no pulse.
- IDLE:
  - If up_q: count<=1, go RUN_UP.
  - If INT_CYCLES==1: count<=0, pulse finished_counting, go RUN_DOWN.
- RUN_UP, on each up_q edge:
  - If count==INT_CYCLES-1: count<=0, pulse finished_counting, go RUN_DOWN.
  - Otherwise count<=count+1.
  - A cycle without up_q holds count (pause, not abort).
- RUN_DOWN, on each dn_q edge, in priority order:
  - If cap_sync: result<=count, result_valid<=1, pulse finished_counting, go HOLD; count not incremented.
  - Else if count==MAX: result<=MAX, overflow<=1, result_valid<=1, pulse finished_counting, go HOLD.
  - Else count<=count+1.
  - cap_sync is ignored in cycles without dn_q.
- HOLD:
  - count, result and flags frozen.
  - Further enables are ignored; only clear_count or reset leave HOLD.
- Both phase selects high in the same cycle: illegal; treated as no qualifying cycle (hold).
- result is the raw count and includes the SYNC_STAGES-cycle synchronizer delay. Downstream compensates; no correction is done here.
- Latency:
  - Raw cap_discharged rise to result_valid: SYNC_STAGES+1 qualifying edges.
  - finished_counting is high the cycle after the terminating edge.

Optional Feature:
- Macro: DUAL_SLOPE_PROTOCOL_CHECK_EN.
- Defined:
  - Adds output protocol_error (1 bit, reset 0).
  - protocol_error is sticky and cleared only by clear_count or reset.
  - It is set on either of: both phase selects high; ch_Vref asserted with enable while in IDLE or RUN_UP.
- Undefined: the port is absent and these conditions are silently held per Behaviour.

Decomposition:
- Shared package dual_slope_pkg:
  - State encoding localparams IDLE=0, RUN_UP=1, RUN_DOWN=2, HOLD=3.
  - Default COUNT_WIDTH, INT_CYCLES and SYNC_STAGES constants, shared with the control machine.
- One sub-module: sync_ff, a parameterized SYNC_STAGES-deep synchronizer for cap_discharged; reusable for other comparator inputs.

Test Plan (COUNT_WIDTH=4, INT_CYCLES=8, SYNC_STAGES=2):
- Reset mid-RUN_UP with count=5 -> all outputs 0 asynchronously; state IDLE.
- Full conversion:
  - Stimulus: 8 up_q cycles; then dn_q continuously; raw cap_discharged rises just after the edge where count becomes 5.
  - Required: finished pulse after the 8th up_q edge; count=0; result=7 latched 3 edges after the cap rise; result_valid=1; second finished pulse; overflow=0.
- Overflow: dn_q held with cap_discharged=0 -> at count=15, result=15, overflow=1, result_valid=1, one finished pulse; count stays 15 in HOLD.
- Pause: enable_counting dropped for 3 cycles at count=4 in RUN_UP -> count holds 4; finished pulse is delayed exactly 3 cycles.
- clear_count at count=6 in RUN_DOWN after a prior result=9 -> state IDLE, count=0, result_valid=0, result stays 9, no finished pulse.
- Both selects high for 2 cycles in RUN_UP -> count unchanged; with DUAL_SLOPE_PROTOCOL_CHECK_EN, protocol_error=1 until clear_count.
